net_to_usb_serializer: RTL and testbench
========================================

# net_to_usb_serializer

Width converter for the outbound path, from the network domain toward USB. It accepts 32-bit words over a valid/ready handshake and emits them one byte at a time, least-significant byte first. This matches the byte order the inbound packer uses, so a round trip preserves byte order. It runs entirely in the `clk` domain and feeds the outbound async FIFO toward the ULPI side. It adds packet framing: a last flag and a byte count for the final word.

## Interface
- `BYTE_W`, default 8: width of an output byte.
- `WORD_BYTES`, default 4: bytes per input word. Must be a power of two; the input word width is `BYTE_W*WORD_BYTES`.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: active-low reset, synchronous to `clk` (one clock; reset is synchronous and active-low).
- `io_n_ready` out 1: the block can accept a word this cycle.
- `io_n_valid` in 1: an input word is offered.
- `io_n_bits` in 32: input word. Byte 0 is `[7:0]` and is sent first.
- `io_n_last` in 1: this word ends a packet.
- `io_n_nbytes` in 2: number of valid bytes in a last word. 0 means 4. Ignored when `io_n_last`=0.
- `io_a_ready` in 1: downstream accepts a byte this cycle.
- `io_a_valid` out 1: an output byte is presented.
- `io_a_bits` out 8: output byte.
- `io_a_last` out 1: the presented byte is the final byte of a packet.

## Operation
- A word transfer happens when `io_n_valid & io_n_ready`. A byte transfer happens when `io_a_valid & io_a_ready`.
- Two states, EMPTY and BUSY. State registers:
  - `sreg` (32b) holds the word being sent.
  - `idx` (2b) is the index of the byte currently presented.
  - `lim` (2b) is the index of the final byte to send.
  - `lastw` (1b) records whether the held word ends a packet.
- On word accept:
  - `sreg` ← `io_n_bits`, `idx` ← 0, `lastw` ← `io_n_last`.
  - `lim` ← `io_n_nbytes-1` (mod 4) if `io_n_last`=1, otherwise 3.
  - State ← BUSY.
- Outputs:
  - `io_a_bits` = `sreg[7:0]`.
  - `io_a_valid` = (state==BUSY).
  - `io_a_last` = BUSY & `lastw` & (`idx`==`lim`).
- Byte transfer with `idx`≠`lim`: `sreg` shifts right by 8 (zero fill) and `idx`+1.
- Byte transfer with `idx`==`lim`: the word is done.
  - If a new word is accepted in the same cycle, load it and stay BUSY; there is no bubble.
  - Otherwise go to EMPTY.
- `io_n_ready` = `reset_n` & (EMPTY | (`io_a_ready` & `idx`==`lim`)).
  - This is a combinational path from `io_a_ready`. It is required for full throughput.
- Bytes past `lim` in a last word are discarded and never presented.
- Backpressure: while `io_a_valid`=1 and `io_a_ready`=0, `io_a_bits`, `io_a_last` and `io_a_valid` hold stable.
- `io_a_valid` never drops without a transfer.

## Timing
- Reset values (next edge with `reset_n`=0):
  - State EMPTY; `sreg`, `idx`, `lim`, `lastw` all 0.
  - Hence `io_a_valid`=0, `io_a_bits`=0x00, `io_a_last`=0.
- `io_n_ready`=0 while `reset_n`=0. It is 1 in the first cycle after release.
- Reset mid-word aborts the word; the remaining bytes are lost. The next accepted word starts at byte 0.
- Latency: a word accepted at edge k presents byte 0 from edge k onward, visible in cycle k+1.
- Throughput is one byte per cycle with continuous `io_a_ready`. A full word takes 4 cycles; a last word with n bytes takes n cycles.
- `io_n_ready` pulses for exactly one cycle per word under continuous flow, in the cycle its final byte transfers.
- If `io_n_valid` rises while EMPTY, the word is accepted the same cycle.

## Structure
- Shared package `usb_bridge_pkg` holds:
  - `BYTE_W`, `WORD_BYTES`;
  - the state enum `ser_state_t` {EMPTY, BUSY};
  - the index width `$clog2(WORD_BYTES)`.
- Single module with no sub-modules; the counter and shifter are inline.
- It is instantiated alongside the outbound `AsyncFifo` in the outbound bridge top.

## Test plan
- Word 0x44332211, last=0, `io_a_ready`=1 → bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; `io_a_last` always 0.
- Two back-to-back words 0x44332211 and 0x88776655, `io_a_ready`=1 → 8 contiguous bytes 0x11..0x88 with no bubble; `io_n_ready` high only during byte 0x44 and byte 0x88.
- Word 0xDDCCBBAA, last=1, nbytes=2 → bytes 0xAA then 0xBB with `io_a_last`=1 on 0xBB; 0xCC and 0xDD never appear; then EMPTY.
- Last word with nbytes=0 → 4 bytes, `io_a_last` on the 4th. Non-last word with nbytes=1 → 4 bytes, no last.
- `io_a_ready` low 3 cycles while 0x22 is presented → 0x22 and `io_a_valid` stay stable; `io_n_ready`=0; the sequence resumes with 0x33.
- `reset_n` low for 1 cycle while 0x22 is presented → next cycle `io_a_valid`=0, `io_a_bits`=0; the following word 0x0D0C0B0A is emitted from 0x0A.

Source files
------------

// File: rtl/usb_bridge_pkg.sv
// Shared definitions for the USB bridge datapath blocks.
//   BYTE_W      : width of one byte on the USB-side stream
//   WORD_BYTES  : bytes per network-side word (power of two)
//   IDX_W       : width of a byte index within a word
//   ser_state_t : serializer state (EMPTY / BUSY)
package usb_bridge_pkg;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = $clog2(WORD_BYTES);

    typedef enum logic {
        EMPTY,
        BUSY
    } ser_state_t;
endpackage

// File: rtl/net_to_usb_serializer_if.sv
// Handshake bundle for net_to_usb_serializer.
//   io_n_* : word stream from the network domain (valid/ready, bits, last, nbytes)
//   io_a_* : byte stream toward the outbound async FIFO (valid/ready, bits, last)
// Modports:
//   slave  : the serializer's view (consumes words, produces bytes)
//   master : the surrounding logic's view (produces words, consumes bytes)
interface net_to_usb_serializer_if
    import usb_bridge_pkg::*;
#(
    parameter int BYTE_W     = usb_bridge_pkg::BYTE_W,
    parameter int WORD_BYTES = usb_bridge_pkg::WORD_BYTES
);
    localparam int SEL_W = $clog2(WORD_BYTES);

    logic                         io_n_ready;
    logic                         io_n_valid;
    logic [BYTE_W*WORD_BYTES-1:0] io_n_bits;
    logic                         io_n_last;
    logic [SEL_W-1:0]             io_n_nbytes;

    logic                         io_a_ready;
    logic                         io_a_valid;
    logic [BYTE_W-1:0]            io_a_bits;
    logic                         io_a_last;

    modport slave (
        input  io_n_valid, io_n_bits, io_n_last, io_n_nbytes,
        output io_n_ready,
        input  io_a_ready,
        output io_a_valid, io_a_bits, io_a_last
    );

    modport master (
        output io_n_valid, io_n_bits, io_n_last, io_n_nbytes,
        input  io_n_ready,
        output io_a_ready,
        input  io_a_valid, io_a_bits, io_a_last
    );
endinterface

// File: rtl/net_to_usb_serializer.sv
// Outbound width converter: accepts WORD_BYTES-byte words and emits them one
// byte per cycle, least-significant byte first, with packet framing.
// Ports:
//   clk     : single clock
//   reset_n : synchronous active-low reset
//   io      : net_to_usb_serializer_if.slave
//             io_n_* word input (valid/ready, bits, last, nbytes; nbytes 0 = full word)
//             io_a_* byte output (valid/ready, bits, last on the packet's final byte)
module net_to_usb_serializer
    import usb_bridge_pkg::*;
#(
    parameter int BYTE_W     = usb_bridge_pkg::BYTE_W,
    parameter int WORD_BYTES = usb_bridge_pkg::WORD_BYTES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    net_to_usb_serializer_if.slave  io
);
    localparam int SEL_W  = $clog2(WORD_BYTES);
    localparam int WORD_W = BYTE_W * WORD_BYTES;

    ser_state_t        state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [SEL_W-1:0]  lim_q, lim_d;
    logic              lastw_q, lastw_d;

    logic busy;
    logic at_lim;
    logic a_fire;
    logic n_fire;
    logic n_ready;

    assign busy   = (state_q == BUSY);
    assign at_lim = (idx_q == lim_q);
    assign a_fire = busy & io.io_a_ready;

    // Ready looks through to io_a_ready so the next word can load in the
    // same cycle the final byte leaves: no bubble between words.
    assign n_ready = reset_n & (~busy | (io.io_a_ready & at_lim));
    assign n_fire  = io.io_n_valid & n_ready;

    assign io.io_n_ready = n_ready;
    assign io.io_a_valid = busy;
    assign io.io_a_bits  = sreg_q[BYTE_W-1:0];
    assign io.io_a_last  = busy & lastw_q & at_lim;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        lim_d   = lim_q;
        lastw_d = lastw_q;

        // A word accept in BUSY implies the final byte is transferring now,
        // so the load takes priority over the shift/advance path.
        if (n_fire) begin
            state_d = BUSY;
            sreg_d  = io.io_n_bits;
            idx_d   = '0;
            lastw_d = io.io_n_last;
            // nbytes wraps: 0 means a full word, so nbytes-1 lands on the top index.
            lim_d   = io.io_n_last ? SEL_W'(io.io_n_nbytes - SEL_W'(1)) : '1;
        end else if (a_fire) begin
            if (at_lim) begin
                state_d = EMPTY;
            end else begin
                sreg_d = sreg_q >> BYTE_W;
                idx_d  = idx_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            sreg_q  <= '0;
            idx_q   <= '0;
            lim_q   <= '0;
            lastw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            lim_q   <= lim_d;
            lastw_q <= lastw_d;
        end
    end
endmodule

// File: tb/tb_net_to_usb_serializer.sv
module tb_net_to_usb_serializer;
    import usb_bridge_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    net_to_usb_serializer_if io ();

    net_to_usb_serializer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] w;
        logic        last;
        logic [1:0]  nb;
    } word_t;

    typedef struct {
        logic [7:0] b;
        logic       last;
        logic       endw;
    } byte_t;

    typedef struct {
        logic       av, ar, al, nr, nv;
        logic [7:0] ab;
    } tr_t;

    word_t wq[$];
    byte_t exp_q[$];
    byte_t obs_q[$];
    tr_t   tr[$];
    logic  rdy_pat[$];
    bit    rand_ready = 1'b0;

    // Reference stream: every word contributes its valid bytes, LSB first.
    task automatic build_exp();
        exp_q.delete();
        foreach (wq[k]) begin
            int n;
            n = wq[k].last ? ((wq[k].nb == 2'd0) ? 4 : int'(wq[k].nb)) : 4;
            for (int i = 0; i < n; i++) begin
                logic [31:0] v;
                v = wq[k].w >> (8 * i);
                exp_q.push_back('{v[7:0], wq[k].last && (i == n - 1), (i == n - 1)});
            end
        end
    endtask

    // Offers wq in order (holding each until accepted) and records a trace.
    task automatic run(input int budget);
        int w;
        bit acc;
        tr_t t;
        w = 0;
        tr.delete();
        obs_q.delete();
        for (int c = 0; c < budget; c++) begin
            io.io_n_valid = (w < wq.size());
            if (w < wq.size()) begin
                io.io_n_bits   = wq[w].w;
                io.io_n_last   = wq[w].last;
                io.io_n_nbytes = wq[w].nb;
            end else begin
                io.io_n_bits   = $urandom;
                io.io_n_last   = 1'($urandom);
                io.io_n_nbytes = 2'($urandom);
            end
            if (rdy_pat.size() > 0) io.io_a_ready = rdy_pat.pop_front();
            else io.io_a_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            t = '{io.io_a_valid, io.io_a_ready, io.io_a_last, io.io_n_ready, io.io_n_valid, io.io_a_bits};
            tr.push_back(t);
            if (t.av && t.ar) obs_q.push_back('{t.ab, t.al, 1'b0});
            acc = t.nv && t.nr;
            if (acc) w++;
            @(negedge clk);
            if (w == wq.size() && !acc && !t.av) break;
        end
        io.io_n_valid = 1'b0;
        io.io_a_ready = 1'b1;
        rdy_pat.delete();
    endtask

    task automatic test_reset();
        io.io_n_valid  = 1'b0;
        io.io_n_bits   = '0;
        io.io_n_last   = 1'b0;
        io.io_n_nbytes = '0;
        io.io_a_ready  = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        io.io_n_valid = 1'b1;
        io.io_n_bits  = 32'hCAFEF00D;
        #1;
        n_checks++;
        if (io.io_n_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nready: got %b expected 0", io.io_n_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        io.io_n_valid = 1'b0;
        #1;
        n_checks++;
        if ({io.io_a_valid, io.io_a_bits, io.io_a_last} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b b=%h l=%b expected v=0 b=00 l=0",
                     io.io_a_valid, io.io_a_bits, io.io_a_last);
        end
        n_checks++;
        if (io.io_n_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_nready: got %b expected 1", io.io_n_ready);
        end
        @(negedge clk);
        n_checks++;
        if (io.io_a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept: got a_valid=%b expected 0", io.io_a_valid);
        end
    endtask

    task automatic test_single_word();
        wq.delete();
        wq.push_back('{32'h44332211, 1'b0, 2'd1});
        build_exp();
        run(20);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_count: got %0d bytes expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if ({obs_q[i].b, obs_q[i].last} !== {exp_q[i].b, exp_q[i].last}) begin
                n_fail++;
                $display("FAIL single_byte[%0d]: got %h/%b expected %h/%b", i,
                         obs_q[i].b, obs_q[i].last, exp_q[i].b, exp_q[i].last);
            end
        end
        n_checks++;
        if (tr.size() < 1 || tr[0].av !== 1'b0 || tr[0].nr !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept_empty: got trace size %0d, expected same-cycle accept", tr.size());
        end
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (k >= tr.size() || tr[k].av !== 1'b1) begin
                n_fail++;
                $display("FAIL single_contig[%0d]: byte not presented, expected a_valid=1", k);
            end
        end
    endtask

    task automatic test_back_to_back();
        wq.delete();
        wq.push_back('{32'h44332211, 1'b0, 2'd0});
        wq.push_back('{32'h88776655, 1'b0, 2'd0});
        build_exp();
        run(30);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d bytes expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if ({obs_q[i].b, obs_q[i].last} !== {exp_q[i].b, exp_q[i].last}) begin
                n_fail++;
                $display("FAIL b2b_byte[%0d]: got %h/%b expected %h/%b", i,
                         obs_q[i].b, obs_q[i].last, exp_q[i].b, exp_q[i].last);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (k >= tr.size() || tr[k].av !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_bubble[%0d]: a_valid low, expected 1", k);
            end else begin
                n_checks++;
                if (tr[k].nr !== (tr[k].ab == 8'h44 || tr[k].ab == 8'h88)) begin
                    n_fail++;
                    $display("FAIL b2b_nready[%0d]: got %b on byte %h", k, tr[k].nr, tr[k].ab);
                end
            end
        end
    endtask

    task automatic test_partial_last();
        wq.delete();
        wq.push_back('{32'hDDCCBBAA, 1'b1, 2'd2});
        build_exp();
        run(20);
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL partial_count: got %0d bytes expected 2", obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if ({obs_q[i].b, obs_q[i].last} !== {exp_q[i].b, exp_q[i].last}) begin
                n_fail++;
                $display("FAIL partial_byte[%0d]: got %h/%b expected %h/%b", i,
                         obs_q[i].b, obs_q[i].last, exp_q[i].b, exp_q[i].last);
            end
        end
        n_checks++;
        if (tr.size() < 4 || tr[3].av !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_empty: got trace size %0d, expected EMPTY after 2 bytes", tr.size());
        end
    endtask

    task automatic test_full_last_and_nonlast();
        wq.delete();
        wq.push_back('{32'h5A6B7C8D, 1'b1, 2'd0});
        wq.push_back('{32'h01020304, 1'b0, 2'd1});
        build_exp();
        run(30);
        n_checks++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL nbytes_count: got %0d bytes expected 8", obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if ({obs_q[i].b, obs_q[i].last} !== {exp_q[i].b, exp_q[i].last}) begin
                n_fail++;
                $display("FAIL nbytes_byte[%0d]: got %h/%b expected %h/%b", i,
                         obs_q[i].b, obs_q[i].last, exp_q[i].b, exp_q[i].last);
            end
        end
    endtask

    task automatic test_backpressure();
        wq.delete();
        wq.push_back('{32'h44332211, 1'b0, 2'd0});
        build_exp();
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run(30);
        for (int k = 2; k <= 4; k++) begin
            n_checks++;
            if (k >= tr.size() || {tr[k].av, tr[k].ab, tr[k].nr} !== {1'b1, 8'h22, 1'b0}) begin
                n_fail++;
                if (k < tr.size())
                    $display("FAIL stall[%0d]: got v=%b b=%h nr=%b expected v=1 b=22 nr=0",
                             k, tr[k].av, tr[k].ab, tr[k].nr);
                else
                    $display("FAIL stall[%0d]: trace too short (%0d)", k, tr.size());
            end
        end
        n_checks++;
        if (tr.size() < 7 || tr[6].ab !== 8'h33) begin
            n_fail++;
            $display("FAIL stall_resume: expected 33 after stall, trace size %0d", tr.size());
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_count: got %0d bytes expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i].b !== exp_q[i].b) begin
                n_fail++;
                $display("FAIL stall_byte[%0d]: got %h expected %h", i, obs_q[i].b, exp_q[i].b);
            end
        end
    endtask

    task automatic test_reset_midword();
        io.io_a_ready  = 1'b1;
        io.io_n_valid  = 1'b1;
        io.io_n_bits   = 32'h44332211;
        io.io_n_last   = 1'b0;
        io.io_n_nbytes = 2'd0;
        @(negedge clk);
        io.io_n_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({io.io_a_valid, io.io_a_bits} !== {1'b1, 8'h22}) begin
            n_fail++;
            $display("FAIL midreset_pre: got v=%b b=%h expected v=1 b=22", io.io_a_valid, io.io_a_bits);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({io.io_a_valid, io.io_a_bits, io.io_a_last} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_post: got v=%b b=%h l=%b expected v=0 b=00 l=0",
                     io.io_a_valid, io.io_a_bits, io.io_a_last);
        end
        @(negedge clk);
        wq.delete();
        wq.push_back('{32'h0D0C0B0A, 1'b0, 2'd0});
        build_exp();
        run(20);
        n_checks++;
        if (obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d bytes expected 4", obs_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if (obs_q[i].b !== exp_q[i].b) begin
                n_fail++;
                $display("FAIL midreset_byte[%0d]: got %h expected %h", i, obs_q[i].b, exp_q[i].b);
            end
        end
    endtask

    task automatic test_random();
        int j;
        wq.delete();
        for (int k = 0; k < 40; k++)
            wq.push_back('{$urandom, 1'($urandom), 2'($urandom)});
        build_exp();
        rand_ready = 1'b1;
        run(2000);
        rand_ready = 1'b0;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d bytes expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++;
            if ({obs_q[i].b, obs_q[i].last} !== {exp_q[i].b, exp_q[i].last}) begin
                n_fail++;
                $display("FAIL rand_byte[%0d]: got %h/%b expected %h/%b", i,
                         obs_q[i].b, obs_q[i].last, exp_q[i].b, exp_q[i].last);
            end
        end
        // Ready must be high when idle, or exactly when a word's final byte leaves.
        j = 0;
        foreach (tr[i]) begin
            logic want;
            if (tr[i].av && tr[i].ar) begin
                want = (j < exp_q.size()) ? exp_q[j].endw : 1'b0;
                j++;
            end else begin
                want = !tr[i].av;
            end
            n_checks++;
            if (tr[i].nr !== want) begin
                n_fail++;
                $display("FAIL rand_nready[%0d]: got %b expected %b", i, tr[i].nr, want);
            end
            if (i + 1 < tr.size() && tr[i].av && !tr[i].ar) begin
                n_checks++;
                if ({tr[i+1].av, tr[i+1].ab, tr[i+1].al} !== {1'b1, tr[i].ab, tr[i].al}) begin
                    n_fail++;
                    $display("FAIL rand_hold[%0d]: got v=%b b=%h l=%b expected v=1 b=%h l=%b", i,
                             tr[i+1].av, tr[i+1].ab, tr[i+1].al, tr[i].ab, tr[i].al);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_partial_last();
        test_full_last_and_nonlast();
        test_backpressure();
        test_reset_midword();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
